// File: rtl/matmul_pkg.sv
// Shared types and default sizes for the matmul result scratchpad.
// The build option MATMUL_SP_CMP_EN is consumed by the interface and the top.
package matmul_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int N_DEF          = 4;
    localparam int M_DEF          = 4;
    localparam int SP_BANKS_DEF   = 4;

    typedef logic signed [2*DATA_WIDTH_DEF-1:0] result_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_DONE
    } sp_state_e;

    // Index widths never collapse to zero bits, so single-entry dimensions still get a port.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/matmul_result_sp_if.sv
// Capture/read bus of the matmul result scratchpad.
// With MATMUL_SP_CMP_EN defined it also carries the expected-data compare signals.
interface matmul_result_sp_if
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int N_DIM      = N_DEF,
    parameter int M_DIM      = M_DEF,
    parameter int SP_BANKS   = SP_BANKS_DEF
);
    localparam int EW = 2 * DATA_WIDTH;
    localparam int BW = clog2_min1(SP_BANKS);
    localparam int RW = clog2_min1(N_DIM);
    localparam int CW = clog2_min1(M_DIM);

    logic                 start_i;
    logic [BW-1:0]        bank_i;
    logic                 wr_valid_i;
    logic signed [EW-1:0] wr_data_i;
    logic                 wr_ready_o;
    logic                 done_o;
    logic [SP_BANKS-1:0]  bank_full_o;
    logic                 rd_en_i;
    logic [BW-1:0]        rd_bank_i;
    logic [RW-1:0]        rd_row_i;
    logic [CW-1:0]        rd_col_i;
    logic signed [EW-1:0] rd_data_o;
    logic                 rd_valid_o;
    logic                 clr_i;
`ifdef MATMUL_SP_CMP_EN
    localparam int IW = $clog2(N_DIM * M_DIM + 1);
    logic signed [EW-1:0] exp_data_i;
    logic [15:0]          err_cnt_o;
    logic [IW-1:0]        first_err_idx_o;
`endif

    modport slave (
`ifdef MATMUL_SP_CMP_EN
        input  exp_data_i,
        output err_cnt_o, first_err_idx_o,
`endif
        input  start_i, bank_i, wr_valid_i, wr_data_i, rd_en_i, rd_bank_i,
               rd_row_i, rd_col_i, clr_i,
        output wr_ready_o, done_o, bank_full_o, rd_data_o, rd_valid_o
    );

    modport master (
`ifdef MATMUL_SP_CMP_EN
        output exp_data_i,
        input  err_cnt_o, first_err_idx_o,
`endif
        output start_i, bank_i, wr_valid_i, wr_data_i, rd_en_i, rd_bank_i,
               rd_row_i, rd_col_i, clr_i,
        input  wr_ready_o, done_o, bank_full_o, rd_data_o, rd_valid_o
    );

endinterface

// File: rtl/matmul_sp_bank.sv
// One result-matrix bank: 1W/1R synchronous RAM, read returns pre-write contents.
module matmul_sp_bank #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/matmul_result_sp.sv
// Result scratchpad: captures row-major matrices into SP_BANKS banks and serves reads.
// Define MATMUL_SP_CMP_EN to add per-element comparison against exp_data_i.
module matmul_result_sp
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int N_DIM      = N_DEF,
    parameter int M_DIM      = M_DEF,
    parameter int SP_BANKS   = SP_BANKS_DEF
) (
    input logic              clk,
    input logic              rst,
    matmul_result_sp_if.slave bus
);
    localparam int EW    = 2 * DATA_WIDTH;
    localparam int DEPTH = N_DIM * M_DIM;
    localparam int AW    = clog2_min1(DEPTH);
    localparam int BW    = clog2_min1(SP_BANKS);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    sp_state_e           state_q, state_d;
    logic [AW-1:0]       cnt_q;
    logic [BW-1:0]       bank_q;
    logic [SP_BANKS-1:0] full_q;
    logic                start_acc, accept, last_acc;
    logic [SP_BANKS-1:0] start_mask, set_mask;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        start_acc      = 1'b0;
        accept         = 1'b0;
        bus.wr_ready_o = 1'b0;
        bus.done_o     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    start_acc = 1'b1;
                    state_d   = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                bus.wr_ready_o = 1'b1;
                accept         = bus.wr_valid_i;
                if (bus.wr_valid_i && cnt_q == LAST) state_d = ST_DONE;
            end
            ST_DONE: begin
                bus.done_o = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign last_acc   = accept && (cnt_q == LAST);
    assign start_mask = start_acc ? (SP_BANKS'(1) << bus.bank_i) : '0;
    assign set_mask   = last_acc  ? (SP_BANKS'(1) << bank_q)     : '0;

    // Full flag rises with the final accept so it is visible during the DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            bank_q <= '0;
            full_q <= '0;
        end else begin
            if (start_acc) begin
                cnt_q  <= '0;
                bank_q <= bus.bank_i;
            end else if (last_acc) begin
                cnt_q <= '0;
            end else if (accept) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (bus.clr_i) full_q <= '0;
            else           full_q <= (full_q & ~start_mask) | set_mask;
        end
    end

    assign bus.bank_full_o = full_q;

    logic [AW-1:0] raddr;
    logic [EW-1:0] bank_dout [SP_BANKS];

    assign raddr = AW'(int'(bus.rd_row_i) * M_DIM + int'(bus.rd_col_i));

    for (genvar b = 0; b < SP_BANKS; b++) begin : g_bank
        matmul_sp_bank #(.WIDTH(EW), .DEPTH(DEPTH), .AW(AW)) u_bank (
            .clk   (clk),
            .we    (accept && bank_q == BW'(b)),
            .waddr (cnt_q),
            .wdata (bus.wr_data_i),
            .re    (bus.rd_en_i && bus.rd_bank_i == BW'(b)),
            .raddr (raddr),
            .rdata (bank_dout[b])
        );
    end

    // Read stage p1: bank RAM output selected, last value held while idle.
    logic          rd_vld_p1;
    logic [BW-1:0] rd_bank_p1;
    logic [EW-1:0] rd_hold_p1;
    logic [EW-1:0] rd_data_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_p1  <= 1'b0;
            rd_bank_p1 <= '0;
            rd_hold_p1 <= '0;
        end else begin
            rd_vld_p1  <= bus.rd_en_i;
            rd_bank_p1 <= bus.rd_bank_i;
            rd_hold_p1 <= rd_data_p1;
        end
    end

    assign rd_data_p1     = rd_vld_p1 ? bank_dout[rd_bank_p1] : rd_hold_p1;
    assign bus.rd_data_o  = rd_data_p1;
    assign bus.rd_valid_o = rd_vld_p1;

`ifdef MATMUL_SP_CMP_EN
    localparam int IW = $clog2(DEPTH + 1);

    logic [15:0]   err_cnt_q;
    logic [IW-1:0] first_err_q;

    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            err_cnt_q   <= '0;
            first_err_q <= '1;
        end else if (accept && bus.wr_data_i != bus.exp_data_i) begin
            if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
            if (first_err_q == '1)     first_err_q <= IW'(cnt_q);
        end
    end

    assign bus.err_cnt_o       = err_cnt_q;
    assign bus.first_err_idx_o = first_err_q;
`endif

endmodule

// File: tb/tb_matmul_result_sp.sv
// Directed bench for matmul_result_sp with a read scoreboard and bank-content model.
// Compare checks run when MATMUL_SP_CMP_EN is defined.
module tb_matmul_result_sp;
    import matmul_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    matmul_result_sp_if bus ();

    matmul_result_sp dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          ncmp = 0;
    int          nerr = 0;
    result_t     rd_q[$];
    result_t     last_rd = '0;
    result_t     exp_mem [4][16];
    logic [3:0]  full_m = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and check the read response that the previous cycle requested.
    task automatic step();
        logic    exp_v;
        result_t e;
        exp_v = bus.rd_en_i;
        if (rst) last_rd = '0;
        @(posedge clk);
        #1;
        chk("rd_valid", 32'(bus.rd_valid_o), 32'(exp_v));
        if (exp_v) begin
            if (rd_q.size() == 0) begin
                chk("rd_queue_underflow", 32'(rd_q.size()), 32'd1);
            end else begin
                e = rd_q.pop_front();
                chk("rd_data", 32'(bus.rd_data_o), 32'(e));
                last_rd = e;
            end
        end else begin
            chk("rd_data_hold", 32'(bus.rd_data_o), 32'(last_rd));
        end
    endtask

    task automatic issue_read(input int bank, input int row, input int col);
        bus.rd_en_i   = 1'b1;
        bus.rd_bank_i = 2'(bank);
        bus.rd_row_i  = 2'(row);
        bus.rd_col_i  = 2'(col);
        rd_q.push_back(exp_mem[bank][row*4+col]);
    endtask

    task automatic read1(input int bank, input int row, input int col);
        issue_read(bank, row, col);
        step();
        bus.rd_en_i = 1'b0;
        step();
    endtask

    task automatic capture(input int bank, input int base, input bit gaps, input bit midstart,
                           input int rbw_k, input logic [15:0] errmask, input bit clr_at_done);
        int acc;
        int cyc;
        bit tog;
        bit take;
        bus.start_i = 1'b1;
        bus.bank_i  = 2'(bank);
        step();
        bus.start_i = 1'b0;
        full_m &= ~(4'b1 << bank);
        chk("ready_after_start", 32'(bus.wr_ready_o), 32'd1);
        chk("full_after_start", 32'(bus.bank_full_o), 32'(full_m));
`ifdef MATMUL_SP_CMP_EN
        chk("err_cnt_cleared", 32'(bus.err_cnt_o), 32'd0);
        chk("first_err_none", 32'(bus.first_err_idx_o), 32'h1f);
`endif
        acc = 0;
        cyc = 0;
        tog = 1'b1;
        while (acc < 16 && cyc < 100) begin
            bus.wr_valid_i = gaps ? tog : 1'b1;
            tog            = ~tog;
            bus.wr_data_i  = 16'(base + acc);
`ifdef MATMUL_SP_CMP_EN
            bus.exp_data_i = errmask[acc] ? ~bus.wr_data_i : bus.wr_data_i;
`endif
            if (midstart && acc == 8) begin
                bus.start_i = 1'b1;
                bus.bank_i  = 2'd1;
            end
            take = bus.wr_valid_i && bus.wr_ready_o;
            if (take && acc == rbw_k) issue_read(bank, acc / 4, acc % 4);
            if (take) exp_mem[bank][acc] = 16'(base + acc);
            step();
            bus.rd_en_i = 1'b0;
            bus.start_i = 1'b0;
            if (take) acc++;
            cyc++;
        end
        bus.wr_valid_i = 1'b0;
        chk("accept_count", 32'(acc), 32'd16);
        full_m |= 4'b1 << bank;
        chk("done_pulse", 32'(bus.done_o), 32'd1);
        chk("ready_in_done", 32'(bus.wr_ready_o), 32'd0);
        chk("full_in_done", 32'(bus.bank_full_o), 32'(full_m));
`ifdef MATMUL_SP_CMP_EN
        chk("err_cnt", 32'(bus.err_cnt_o), 32'($countones(errmask)));
`endif
        bus.clr_i = clr_at_done;
        step();
        bus.clr_i = 1'b0;
        if (clr_at_done) full_m = '0;
        chk("done_low", 32'(bus.done_o), 32'd0);
        chk("full_after_done", 32'(bus.bank_full_o), 32'(full_m));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start_i    = 1'b0;
        bus.bank_i     = '0;
        bus.wr_valid_i = 1'b0;
        bus.wr_data_i  = '0;
        bus.rd_en_i    = 1'b0;
        bus.rd_bank_i  = '0;
        bus.rd_row_i   = '0;
        bus.rd_col_i   = '0;
        bus.clr_i      = 1'b0;
`ifdef MATMUL_SP_CMP_EN
        bus.exp_data_i = '0;
`endif
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_ready", 32'(bus.wr_ready_o), 32'd0);
        chk("rst_done", 32'(bus.done_o), 32'd0);
        chk("rst_full", 32'(bus.bank_full_o), 32'd0);
        step();

        // Gapless capture into bank 2, values 1..16
        capture(2, 1, 1'b0, 1'b0, -1, 16'h0, 1'b0);
        chk("full_bank2", 32'(bus.bank_full_o), 32'b0100);
        read1(2, 3, 3);
        read1(2, 0, 0);

        // Gapped capture into bank 0, then back-to-back reads of all elements
        capture(0, 101, 1'b1, 1'b0, -1, 16'h0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            issue_read(0, k / 4, k % 4);
            step();
        end
        bus.rd_en_i = 1'b0;
        step();

        // start_i pulsed mid-capture must not retarget the bank
        capture(3, 300, 1'b0, 1'b1, -1, 16'h0, 1'b0);
        chk("full_midstart", 32'(bus.bank_full_o), 32'b1101);
        read1(3, 1, 2);

        // Reset after 7 elements of a bank 1 capture
        bus.start_i = 1'b1;
        bus.bank_i  = 2'd1;
        step();
        bus.start_i = 1'b0;
        for (int k = 0; k < 7; k++) begin
            bus.wr_valid_i = 1'b1;
            bus.wr_data_i  = 16'(90 + k);
            exp_mem[1][k]  = 16'(90 + k);
            step();
        end
        bus.wr_valid_i = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        full_m = '0;
        chk("rst_mid_ready", 32'(bus.wr_ready_o), 32'd0);
        chk("rst_mid_full", 32'(bus.bank_full_o), 32'd0);
        chk("rst_mid_done", 32'(bus.done_o), 32'd0);
        step();
        capture(1, 200, 1'b0, 1'b0, -1, 16'h0, 1'b0);
        read1(1, 0, 0);
        read1(1, 1, 2);

        // Restart bank 1 (clears its flag), read-before-write at element 4, clr_i with done_o
        capture(1, 150, 1'b0, 1'b0, 4, 16'h0, 1'b1);
        chk("full_after_clr", 32'(bus.bank_full_o), 32'd0);
        read1(1, 1, 0);
        read1(2, 2, 1);

`ifdef MATMUL_SP_CMP_EN
        capture(2, 60, 1'b0, 1'b0, -1, 16'h0220, 1'b0);
        chk("err_cnt_two", 32'(bus.err_cnt_o), 32'd2);
        chk("first_err_idx", 32'(bus.first_err_idx_o), 32'd5);
`endif

        chk("rd_queue_empty", 32'(rd_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/matmul_result_sp.md
MATMUL_RESULT_SP -- requirements
Module: matmul_result_sp

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, operand element width; result element width is 2*DATA_WIDTH.
REQ-002 SHALL have parameter N_DIM, default 4, result matrix rows.
REQ-003 SHALL have parameter M_DIM, default 4, result matrix columns.
REQ-004 SHALL have parameter SP_BANKS, default 4, number of independent result-matrix banks (power of two, >=1).
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-007 SHALL have port start_i, input, 1, single-cycle request to begin capturing one matrix.
REQ-008 SHALL have port bank_i, input, log2(SP_BANKS), target bank, sampled with start_i.
REQ-009 SHALL have port wr_valid_i, input, 1, result element valid.
REQ-010 SHALL have port wr_data_i, input, 2*DATA_WIDTH, result element, row-major order.
REQ-011 SHALL have port wr_ready_o, output, 1, element accepted when wr_valid_i && wr_ready_o.
REQ-012 SHALL have port done_o, output, 1, one-cycle pulse when the last element of a matrix is accepted.
REQ-013 SHALL have port bank_full_o, output, SP_BANKS, per-bank flag: bank holds a complete matrix.
REQ-014 SHALL have ports rd_en_i (1), rd_bank_i (log2 SP_BANKS), rd_row_i (log2 N_DIM), rd_col_i (log2 M_DIM), inputs, read request.
REQ-015 SHALL have ports rd_data_o (2*DATA_WIDTH) and rd_valid_o (1), outputs, read response.
REQ-016 SHALL have input clr_i, 1, clears all bank_full_o bits.

Function
REQ-017 SHALL implement FSM IDLE -> CAPTURE on start_i; CAPTURE -> DONE on acceptance of element N_DIM*M_DIM-1; DONE -> IDLE after one cycle.
REQ-018 SHALL drive wr_ready_o = 1 only in CAPTURE; elements offered in IDLE/DONE are not accepted and not stored.
REQ-019 SHALL write accepted element k to bank address k (row = k / M_DIM, col = k % M_DIM), k counting 0..N_DIM*M_DIM-1, no skipped or repeated addresses under wr_valid_i gaps.
REQ-020 SHALL assert done_o in the DONE cycle and set bank_full_o[bank] in that same cycle.
REQ-021 SHALL clear bank_full_o[bank] on the cycle start_i is accepted for that bank.
REQ-022 SHALL ignore start_i while in CAPTURE or DONE (no restart, no bank change).
REQ-023 SHALL return rd_data_o/rd_valid_o exactly one cycle after rd_en_i; rd_valid_o low otherwise; rd_data_o holds last value when rd_valid_o low.
REQ-024 SHALL serve a read from the bank under capture; an address written in the same cycle returns old data (read-before-write).
REQ-025 SHALL on clr_i zero bank_full_o; clr_i and done_o in the same cycle: clr_i wins; clr_i does not abort a capture.

Reset
REQ-026 SHALL on rst: FSM IDLE, element counter 0, wr_ready_o 0, done_o 0, bank_full_o 0, rd_valid_o 0, rd_data_o 0; bank contents not cleared.
REQ-027 SHALL abort a capture in progress on rst; the partly written bank stays not-full.

Configuration
REQ-028 SHALL compile, with macro MATMUL_SP_CMP_EN defined, an input exp_data_i (2*DATA_WIDTH) sampled with each accepted element, outputs err_cnt_o (16-bit, saturating, cleared on start_i and rst) and first_err_idx_o (index of first mismatch in the current matrix, all-ones if none).
REQ-029 SHALL, without MATMUL_SP_CMP_EN, have no exp_data_i, err_cnt_o or first_err_idx_o ports and no compare logic.

Structure
REQ-030 SHALL take DATA_WIDTH, N, M and the result element type from matmul_pkg; SP_BANKS default and the FSM state enum SHALL live in matmul_pkg.
REQ-031 SHALL instantiate one sub-module matmul_sp_bank per bank (1W/1R synchronous RAM, N_DIM*M_DIM words).

Verification
REQ-032 SHALL cover: start_i bank 2, 16 elements 1..16 back-to-back -> done_o at cycle after 16th accept, bank_full_o = 4'b0100, read (3,3) -> 16 after 1 cycle.
REQ-033 SHALL cover: wr_valid_i toggling every other cycle -> exactly 16 accepts, bank contents row-major identical to gapless case.
REQ-034 SHALL cover: start_i pulsed mid-capture with bank 1 -> ignored, capture completes into original bank.
REQ-035 SHALL cover: rst after 7 elements -> IDLE, wr_ready_o 0, bank_full_o 0; new capture starts at address 0.
REQ-036 SHALL cover: clr_i coincident with done_o -> bank_full_o 0.
REQ-037 SHALL cover (MATMUL_SP_CMP_EN): exp_data_i differs at elements 5 and 9 -> err_cnt_o 2, first_err_idx_o 5.
